// File: rtl/pmp_read_responder.sv
`default_nettype none
// ============================================================================
// Module : pmp_read_responder
// Brief  : PMP responder. It answers MCU read strobes with FIFO bytes or a status byte.
// Rev    : 1.0  initial release
// ============================================================================
module pmp_read_responder #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       pmenb,
  input  logic       pmwrn,
  input  logic       pmdc,
  input  logic       pmcs1,
  output logic [7:0] pmd,
  output logic       pmd_oe,
  output logic [5:0] level,
  output logic       underrun
);

  localparam logic [5:0] c_full_level = 6'(DEPTH);

  logic          r_en_s1, r_en_s2, r_en_d;
  logic          r_wrn_s1, r_wrn_s2;
  logic          r_dc_s1, r_dc_s2;
  logic          r_cs_s1, r_cs_s2;
  logic [1:0]    r_sync_vld;
  logic          r_armed;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [5:0]    r_level;
  logic [7:0]    r_pmd;
  logic          r_pmd_oe;
  logic          r_underrun;

  logic          w_acc;
  logic          w_empty;
  logic          w_push;
  logic          w_data_rd;
  logic          w_stat_rd;
  logic          w_pop;

  // Two-flop synchronizers plus edge history. r_armed blocks an access until
  // pmenb has been seen low after reset, so a strobe that is still high when
  // reset is released is not counted as a new access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_s1    <= 1'b0;
      r_en_s2    <= 1'b0;
      r_en_d     <= 1'b0;
      r_wrn_s1   <= 1'b0;
      r_wrn_s2   <= 1'b0;
      r_dc_s1    <= 1'b0;
      r_dc_s2    <= 1'b0;
      r_cs_s1    <= 1'b0;
      r_cs_s2    <= 1'b0;
      r_sync_vld <= 2'b00;
      r_armed    <= 1'b0;
    end else begin
      r_en_s1    <= pmenb;
      r_en_s2    <= r_en_s1;
      r_en_d     <= r_en_s2;
      r_wrn_s1   <= pmwrn;
      r_wrn_s2   <= r_wrn_s1;
      r_dc_s1    <= pmdc;
      r_dc_s2    <= r_dc_s1;
      r_cs_s1    <= pmcs1;
      r_cs_s2    <= r_cs_s1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      if (r_sync_vld[1] && !r_en_s2) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign w_acc     = r_armed & r_en_s2 & ~r_en_d & r_cs_s2 & r_wrn_s2;
  assign w_empty   = (r_level == 6'd0);
  assign wr_ready  = (r_level != c_full_level);
  assign w_push    = wr_valid & wr_ready;
  assign w_data_rd = w_acc & r_dc_s2;
  assign w_stat_rd = w_acc & ~r_dc_s2;
  assign w_pop     = w_data_rd & ~w_empty;

  // Storage has no reset: clearing the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= 6'd0;
      r_pmd      <= 8'h00;
      r_pmd_oe   <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_pmd_oe <= r_cs_s2 & r_wrn_s2;

      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 6'd1;
        2'b01:   r_level <= r_level - 6'd1;
        default: r_level <= r_level;
      endcase

      if (w_data_rd) begin
        if (w_empty) begin
          r_pmd      <= 8'h00;
          r_underrun <= 1'b1;
        end else begin
          r_pmd <= r_mem[r_rptr];
        end
      end else if (w_stat_rd) begin
        // The returned byte carries the pre-clear underrun value.
        r_pmd      <= {w_empty, r_underrun, r_level};
        r_underrun <= 1'b0;
      end
    end
  end

  assign pmd      = r_pmd;
  assign pmd_oe   = r_pmd_oe;
  assign level    = r_level;
  assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_pmp_read_responder.sv
`default_nettype none
// Testbench for pmp_read_responder. It checks the block against a queue-based model of the FIFO and status.
module tb_pmp_read_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       pmenb = 1'b0;
  logic       pmwrn = 1'b1;
  logic       pmdc = 1'b1;
  logic       pmcs1 = 1'b0;
  logic [7:0] pmd;
  logic       pmd_oe;
  logic [5:0] level;
  logic       underrun;

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  logic       m_under = 1'b0;
  logic [7:0] m_pmd = 8'h00;

  pmp_read_responder #(.DEPTH(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .pmenb(pmenb), .pmwrn(pmwrn), .pmdc(pmdc), .pmcs1(pmcs1),
    .pmd(pmd), .pmd_oe(pmd_oe), .level(level), .underrun(underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  // Reference behaviour of one read access, computed from the queue.
  function automatic logic [7:0] model_access(input logic dc);
    logic [7:0] r;
    if (dc) begin
      if (q.size() > 0) r = q.pop_front();
      else begin
        r = 8'h00;
        m_under = 1'b1;
      end
    end else begin
      r = {q.size() == 0, m_under, 6'(q.size())};
      m_under = 1'b0;
    end
    return r;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    wr_data  = b;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    if (q.size() < 32) q.push_back(b);
  endtask

  // One PMP strobe, held high 6 clocks. Returns pmd after edges 2 and 3.
  task automatic do_access(input logic dc, input logic wrn, input logic cs,
                           output logic [7:0] early, output logic [7:0] late,
                           output logic oe_any);
    oe_any = 1'b0;
    @(negedge clk);
    pmdc = dc; pmwrn = wrn; pmcs1 = cs; pmenb = 1'b1;
    @(posedge clk); #1 oe_any |= pmd_oe;
    @(posedge clk); #1 oe_any |= pmd_oe; early = pmd;
    @(posedge clk); #1 oe_any |= pmd_oe; late = pmd;
    repeat (3) begin
      @(posedge clk); #1 oe_any |= pmd_oe;
    end
    @(negedge clk);
    pmenb = 1'b0; pmcs1 = 1'b0; pmwrn = 1'b1; pmdc = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    checks++; if (pmd !== 8'h00) begin failures++; $display("FAIL reset_pmd: got %h want 00", pmd); end
    checks++; if (pmd_oe !== 1'b0) begin failures++; $display("FAIL reset_oe: got %b want 0", pmd_oe); end
    checks++; if (level !== 6'd0) begin failures++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
  endtask

  task automatic test_data_read;
    logic [7:0] vals[3];
    logic [7:0] e, l, prev, exp;
    logic o;
    int n;
    vals = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) push_byte(vals[i]);
    n = $urandom_range(1, 8);
    for (int i = 0; i < n; i++) push_byte(8'($urandom));
    checks++; if (level !== 6'(q.size())) begin failures++; $display("FAIL rd_level_fill: got %0d want %0d", level, q.size()); end
    while (q.size() > 0) begin
      prev = m_pmd;
      exp  = model_access(1'b1);
      do_access(1'b1, 1'b1, 1'b1, e, l, o);
      m_pmd = exp;
      checks++; if (e !== prev) begin failures++; $display("FAIL rd_early: got %h want %h", e, prev); end
      checks++; if (l !== exp) begin failures++; $display("FAIL rd_data: got %h want %h", l, exp); end
      checks++; if (level !== 6'(q.size())) begin failures++; $display("FAIL rd_level: got %0d want %0d", level, q.size()); end
      checks++; if (o !== 1'b1) begin failures++; $display("FAIL rd_oe: got %b want 1", o); end
    end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL rd_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_underrun_status;
    logic [7:0] e, l, exp;
    logic o;
    exp = model_access(1'b1);
    do_access(1'b1, 1'b1, 1'b1, e, l, o);
    m_pmd = exp;
    checks++; if (l !== 8'h00) begin failures++; $display("FAIL ur_data: got %h want 00", l); end
    checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL ur_flag: got %b want 1", underrun); end
    for (int i = 0; i < 2; i++) begin
      exp = model_access(1'b0);
      do_access(1'b0, 1'b1, 1'b1, e, l, o);
      m_pmd = exp;
      checks++; if (l !== exp) begin failures++; $display("FAIL ur_status%0d: got %h want %h", i, l, exp); end
      checks++; if (underrun !== m_under) begin failures++; $display("FAIL ur_clear%0d: got %b want %b", i, underrun, m_under); end
    end
  endtask

  task automatic test_fill;
    logic [7:0] e, l, exp;
    logic o;
    for (int i = 0; i < 32; i++) push_byte(8'(i));
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL fill_wr_ready: got %b want 0", wr_ready); end
    push_byte(8'hAA);
    checks++; if (level !== 6'd32) begin failures++; $display("FAIL fill_level: got %0d want 32", level); end
    exp = model_access(1'b0);
    do_access(1'b0, 1'b1, 1'b1, e, l, o);
    m_pmd = exp;
    checks++; if (l !== 8'h20) begin failures++; $display("FAIL fill_status: got %h want 20", l); end
    for (int i = 0; i < 32; i++) begin
      exp = model_access(1'b1);
      do_access(1'b1, 1'b1, 1'b1, e, l, o);
      m_pmd = exp;
      checks++; if (l !== 8'(i) || l !== exp) begin failures++; $display("FAIL fill_read%0d: got %h want %h", i, l, exp); end
    end
    checks++; if (underrun !== 1'b0 || level !== 6'd0) begin failures++; $display("FAIL fill_end: got ur=%b lvl=%0d want ur=0 lvl=0", underrun, level); end
  endtask

  task automatic test_full_pop_push;
    logic [7:0] e, l, exp, hold;
    logic o;
    for (int i = 0; i < 32; i++) push_byte(8'($urandom));
    hold = 8'($urandom);
    @(negedge clk);
    wr_data = hold; wr_valid = 1'b1;
    pmdc = 1'b1; pmwrn = 1'b1; pmcs1 = 1'b1; pmenb = 1'b1;
    exp = model_access(1'b1);
    @(posedge clk); @(posedge clk); #1;
    checks++; if (level !== 6'd32) begin failures++; $display("FAIL fp_level_pre: got %0d want 32", level); end
    @(posedge clk); #1;
    checks++; if (pmd !== exp) begin failures++; $display("FAIL fp_data: got %h want %h", pmd, exp); end
    checks++; if (level !== 6'd31) begin failures++; $display("FAIL fp_level_pop: got %0d want 31", level); end
    @(posedge clk); #1;
    q.push_back(hold);
    checks++; if (level !== 6'd32) begin failures++; $display("FAIL fp_level_push: got %0d want 32", level); end
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    pmenb = 1'b0; pmcs1 = 1'b0;
    repeat (3) @(negedge clk);
    m_pmd = exp;
    while (q.size() > 0) begin
      exp = model_access(1'b1);
      do_access(1'b1, 1'b1, 1'b1, e, l, o);
      m_pmd = exp;
      checks++; if (l !== exp) begin failures++; $display("FAIL fp_drain: got %h want %h", l, exp); end
    end
  endtask

  task automatic test_ignored;
    logic [7:0] e, l, exp;
    logic o;
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    do_access(1'b1, 1'b0, 1'b1, e, l, o);
    checks++; if (l !== m_pmd || level !== 6'd2 || o !== 1'b0) begin failures++; $display("FAIL ign_write: got pmd=%h lvl=%0d oe=%b want pmd=%h lvl=2 oe=0", l, level, o, m_pmd); end
    do_access(1'b1, 1'b1, 1'b0, e, l, o);
    checks++; if (l !== m_pmd || level !== 6'd2 || o !== 1'b0) begin failures++; $display("FAIL ign_nocs: got pmd=%h lvl=%0d oe=%b want pmd=%h lvl=2 oe=0", l, level, o, m_pmd); end
    while (q.size() > 0) begin
      exp = model_access(1'b1);
      do_access(1'b1, 1'b1, 1'b1, e, l, o);
      m_pmd = exp;
      checks++; if (l !== exp) begin failures++; $display("FAIL ign_read: got %h want %h", l, exp); end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] e, l, exp;
    logic o;
    for (int i = 0; i < 5; i++) push_byte(8'($urandom_range(1, 255)));
    @(negedge clk);
    pmdc = 1'b1; pmwrn = 1'b1; pmcs1 = 1'b1; pmenb = 1'b1;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    checks++; if (pmd !== 8'h00 || pmd_oe !== 1'b0 || level !== 6'd0 || underrun !== 1'b0 || wr_ready !== 1'b1)
      begin failures++; $display("FAIL rm_async: got pmd=%h oe=%b lvl=%0d ur=%b rdy=%b want 00/0/0/0/1", pmd, pmd_oe, level, underrun, wr_ready); end
    q.delete(); m_under = 1'b0; m_pmd = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (underrun !== 1'b0 || level !== 6'd0 || pmd !== 8'h00) begin failures++; $display("FAIL rm_no_access: got ur=%b lvl=%0d pmd=%h want 0/0/00", underrun, level, pmd); end
    @(negedge clk);
    pmenb = 1'b0; pmcs1 = 1'b0;
    repeat (3) @(negedge clk);
    exp = model_access(1'b1);
    do_access(1'b1, 1'b1, 1'b1, e, l, o);
    m_pmd = exp;
    checks++; if (l !== 8'h00 || underrun !== 1'b1) begin failures++; $display("FAIL rm_read: got pmd=%h ur=%b want 00/1", l, underrun); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    test_reset;
    test_data_read;
    test_underrun_status;
    test_fill;
    test_full_pop_push;
    test_ignored;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
